// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl
//   Simon game controller. It holds the FSM, the pattern memory and the index
//   counters in one block. It sits between the debounced button/switch front
//   end and the LED driver.
//
//   Optional build macro: SIMON_TIMEOUT_EN. When it is defined, the player has
//   TIMEOUT_TICKS playback ticks for each press in REPEAT. If no press arrives
//   in that time, the game is lost.
//
// Parameters
//   W             pattern width (buttons/LEDs), 2..8
//   DEPTH         maximum sequence length, >= 2
//   TIMEOUT_TICKS ticks allowed per press in REPEAT (timeout build only)
//   CW            counter width, derived, not overridable
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   level        0: any nonzero pattern is legal, 1: exactly one bit set
//   btn_in       current button pattern
//   btn_press    one-cycle pulse, btn_in valid
//   tick         one-cycle playback pacing pulse
//   pattern_out  pattern shown on the LEDs
//   mode_leds    INPUT 001, PLAYBACK 010, REPEAT 100, DONE 111
//   seq_len      number of patterns stored so far
//   win / lose   game result, valid in DONE
module simon_seq_ctrl #(
  parameter int W             = 4,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 8,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          level,
  input  logic [W-1:0]  btn_in,
  input  logic          btn_press,
  input  logic          tick,
  output logic [W-1:0]  pattern_out,
  output logic [2:0]    mode_leds,
  output logic [CW-1:0] seq_len,
  output logic          win,
  output logic          lose
);

  // Memory address width. Indices are kept CW wide so they share arithmetic
  // with the counter, and they are narrowed only where they address memory.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (W < 2 || W > 8 || DEPTH < 2 || TIMEOUT_TICKS < 1) begin : g_param_check
    $error("simon_seq_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_INPUT,
    S_PLAYBACK,
    S_REPEAT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_play_idx;
  logic [CW-1:0] r_rep_idx;
  logic          r_win;
  logic          r_lose;
  logic [W-1:0]  r_mem [DEPTH];

  logic          w_legal;
  logic          w_last_play;
  logic          w_last_rep;
  logic          w_full;
  logic          w_match;
  logic          w_wr;
  logic          w_timeout;
  logic [W-1:0]  w_play_pat;

  // Zero is never a legal pattern. In level 1, a one-hot pattern is required.
  assign w_legal     = (btn_in != '0) && (!level || ($countones(btn_in) == 1));
  assign w_last_play = (r_play_idx == r_count - CW'(1));
  assign w_last_rep  = (r_rep_idx == r_count - CW'(1));
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_match     = (btn_in == r_mem[r_rep_idx[AW-1:0]]);
  assign w_play_pat  = r_mem[r_play_idx[AW-1:0]];
  // count < DEPTH whenever INPUT is active, so the write address is in range.
  assign w_wr        = (r_state == S_INPUT) && btn_press && w_legal;

`ifdef SIMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] r_to_cnt;

  // The counter is held at zero outside REPEAT, which clears it on REPEAT
  // entry. A press also clears it.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_REPEAT || btn_press)
      r_to_cnt <= '0;
    else if (tick)
      r_to_cnt <= r_to_cnt + TW'(1);
  end

  // Expires on the tick that would bring the count to TIMEOUT_TICKS.
  assign w_timeout = tick && (r_to_cnt == TW'(TIMEOUT_TICKS - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Pattern memory. Reset does not clear it.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_count[AW-1:0]] <= btn_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INPUT;
      r_count    <= '0;
      r_play_idx <= '0;
      r_rep_idx  <= '0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      case (r_state)
        S_INPUT: begin
          if (btn_press && w_legal) begin
            r_count    <= r_count + CW'(1);
            r_play_idx <= '0;
            r_state    <= S_PLAYBACK;
          end
        end
        S_PLAYBACK: begin
          if (tick) begin
            if (w_last_play) begin
              r_play_idx <= '0;
              r_rep_idx  <= '0;
              r_state    <= S_REPEAT;
            end else begin
              r_play_idx <= r_play_idx + CW'(1);
            end
          end
        end
        S_REPEAT: begin
          // A press wins over an expiring timeout tick in the same cycle.
          if (btn_press) begin
            if (!w_match) begin
              r_lose  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_last_rep) begin
              if (w_full) begin
                r_win   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_INPUT;
              end
            end else begin
              r_rep_idx <= r_rep_idx + CW'(1);
            end
          end else if (w_timeout) begin
            r_lose  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Replays the stored sequence in a loop until reset.
          if (tick)
            r_play_idx <= w_last_play ? '0 : r_play_idx + CW'(1);
        end
        default: r_state <= S_INPUT;
      endcase
    end
  end

  always_comb begin
    pattern_out = btn_in;
    mode_leds   = 3'b001;
    case (r_state)
      S_INPUT: begin
        pattern_out = btn_in;
        mode_leds   = 3'b001;
      end
      S_PLAYBACK: begin
        pattern_out = w_play_pat;
        mode_leds   = 3'b010;
      end
      S_REPEAT: begin
        pattern_out = btn_in;
        mode_leds   = 3'b100;
      end
      S_DONE: begin
        pattern_out = w_play_pat;
        mode_leds   = 3'b111;
      end
      default: begin
        pattern_out = btn_in;
        mode_leds   = 3'b001;
      end
    endcase
  end

  assign seq_len = r_count;
  assign win     = r_win;
  assign lose    = r_lose;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Testbench for simon_seq_ctrl (W=4, DEPTH=4).
// The stimulus side drives one input vector per cycle. It advances a
// rule-level game model (a queue of stored patterns plus play/repeat
// positions) and pushes the expected outputs into a scoreboard queue. A
// monitor pops one entry on each falling edge and compares it to the DUT.
module tb_simon_seq_ctrl;

  localparam int W             = 4;
  localparam int DEPTH         = 4;
  localparam int TIMEOUT_TICKS = 8;
  localparam int CW            = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          level;
  logic [W-1:0]  btn_in;
  logic          btn_press;
  logic          tick;
  logic [W-1:0]  pattern_out;
  logic [2:0]    mode_leds;
  logic [CW-1:0] seq_len;
  logic          win;
  logic          lose;

  simon_seq_ctrl #(
    .W(W),
    .DEPTH(DEPTH),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .level(level),
    .btn_in(btn_in),
    .btn_press(btn_press),
    .tick(tick),
    .pattern_out(pattern_out),
    .mode_leds(mode_leds),
    .seq_len(seq_len),
    .win(win),
    .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    mode;
    logic [W-1:0]  pat;
    logic [CW-1:0] len;
    logic          win;
    logic          lose;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Game model: 0 input, 1 playback, 2 repeat, 3 done.
  int           m_mode = 0;
  logic [W-1:0] seq[$];
  int           pidx   = 0;
  int           ridx   = 0;
  int           tocnt  = 0;
  logic         m_win  = 1'b0;
  logic         m_lose = 1'b0;

  function automatic logic [2:0] leds_of(int m);
    case (m)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic p, input logic [W-1:0] b,
                            input logic t, input logic l);
    if (r) begin
      m_mode = 0; seq.delete(); pidx = 0; ridx = 0; tocnt = 0;
      m_win = 1'b0; m_lose = 1'b0;
    end else begin
      case (m_mode)
        0: if (p && b != '0 && (!l || $countones(b) == 1)) begin
             seq.push_back(b); pidx = 0; m_mode = 1;
           end
        1: if (t) begin
             if (pidx == seq.size() - 1) begin
               pidx = 0; ridx = 0; tocnt = 0; m_mode = 2;
             end else pidx++;
           end
        2: begin
             if (p) begin
               tocnt = 0;
               if (b != seq[ridx]) begin m_lose = 1'b1; m_mode = 3; end
               else if (ridx == seq.size() - 1) begin
                 if (seq.size() == DEPTH) begin m_win = 1'b1; m_mode = 3; end
                 else m_mode = 0;
               end else ridx++;
             end
`ifdef SIMON_TIMEOUT_EN
             else if (t) begin
               tocnt++;
               if (tocnt == TIMEOUT_TICKS) begin m_lose = 1'b1; m_mode = 3; end
             end
`endif
           end
        default: if (t) pidx = (pidx + 1) % seq.size();
      endcase
    end
  endtask

  // One clock cycle: drive the inputs, advance the model, push the expectation.
  task automatic step(input logic r, input logic p, input logic [W-1:0] b,
                      input logic t, input logic l);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; btn_press = p; btn_in = b; tick = t; level = l;
    cyc++;
    model_step(r, p, b, t, l);
    e.mode = leds_of(m_mode);
    e.pat  = (m_mode == 0 || m_mode == 2) ? b : seq[pidx];
    e.len  = CW'(seq.size());
    e.win  = m_win;
    e.lose = m_lose;
    e.cyc  = cyc;
    sb.push_back(e);
    if (r || p)
      $display("cyc=%0d rst=%0d press=%0d btn=%b lvl=%0d tick=%0d -> mode=%b len=%0d win=%0d lose=%0d",
               cyc, r, p, b, l, t, e.mode, e.len, e.win, e.lose);
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mode_leds",   e.cyc, 32'(mode_leds),   32'(e.mode));
      chk("pattern_out", e.cyc, 32'(pattern_out), 32'(e.pat));
      chk("seq_len",     e.cyc, 32'(seq_len),     32'(e.len));
      chk("win",         e.cyc, 32'(win),         32'(e.win));
      chk("lose",        e.cyc, 32'(lose),        32'(e.lose));
    end
  end

  task automatic do_reset();
    step(1'b1, 1'b0, 4'(0), 1'b0, 1'b0);
  endtask

  // Add one pattern, run playback to REPEAT, then repeat the whole sequence.
  task automatic add_round(input logic [W-1:0] b);
    step(1'b0, 1'b1, b, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    for (int k = 0; k < 20 && m_mode == 1; k++)
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
    for (int i = 0; i < seq.size(); i++)
      step(1'b0, 1'b1, seq[i], 1'b0, 1'b1);
  endtask

  initial begin
    logic          r, p, t, l;
    logic [W-1:0]  b;
    rst = 1'b1; btn_press = 1'b0; btn_in = '0; tick = 1'b0; level = 1'b0;
    do_reset();
    do_reset();

    // Illegal presses in level 1 are ignored. Level 0 accepts a two-bit pattern.
    step(1'b0, 1'b1, 4'b0011, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0110, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);

    // Lose: build 0001, 0010, then repeat 0001 and 0100.
    do_reset();
    add_round(4'b0001);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
      step(1'b0, 1'b0, 4'b1111, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0100, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1);
      step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    end

    // Reset in the middle of a three-entry playback.
    do_reset();
    add_round(4'b0001);
    add_round(4'b0010);
    step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 4'b1010, 1'b0, 1'b1);

    // Win with a full-length sequence. DONE then holds.
    add_round(4'b0001);
    add_round(4'b0010);
    add_round(4'b0100);
    add_round(4'b1000);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
    end

`ifdef SIMON_TIMEOUT_EN
    // Eight ticks with no press cause a timeout.
    do_reset();
    step(1'b0, 1'b1, 4'b0010, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < TIMEOUT_TICKS + 2; k++) begin
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    end
    // A press on the eighth tick is compared normally.
    do_reset();
    step(1'b0, 1'b1, 4'b0010, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < TIMEOUT_TICKS - 1; k++)
      step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0010, 1'b1, 1'b1);
`endif

    // Randomised play, biased toward correct repeats so that games progress.
    for (int n = 0; n < 4000; n++) begin
      r = (m_mode == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 2) == 0);
      l = 1'($urandom_range(0, 1));
      if (m_mode == 2 && $urandom_range(0, 7) != 0)
        b = seq[ridx];
      else
        b = 4'($urandom_range(0, 15));
      step(r, p, b, t, l);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_seq_ctrl.md
Name: simon_seq_ctrl

Overview:
Parametrised Simon game controller: FSM, pattern memory and index counters in one block. Replaces the split control/datapath pair for the next board revision. Supports configurable button count, maximum sequence length and a playback pacing tick. Sits between the debounced button/switch front end and the LED driver.

Parameters:
W, 4, pattern width (number of buttons/LEDs), 2..8
DEPTH, 16, maximum sequence length (memory entries), >=2
CW, $clog2(DEPTH+1), counter width (derived localparam, not overridable)
TIMEOUT_TICKS, 8, ticks allowed per press in REPEAT (used only with SIMON_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
level  in  1  0 = any nonzero pattern legal; 1 = exactly one bit set
btn_in  in  W  current pattern on buttons
btn_press  in  1  one-cycle pulse, btn_in valid
tick  in  1  one-cycle playback pacing pulse (~1 Hz)
pattern_out  out  W  pattern shown on LEDs
mode_leds  out  3  INPUT 001, PLAYBACK 010, REPEAT 100, DONE 111
seq_len  out  CW  patterns stored so far
win  out  1  high in DONE after completing DEPTH-length sequence
lose  out  1  high in DONE after a mismatch or timeout

Behaviour:
- Reset (rst high at clk edge): state INPUT; count, play_idx, rep_idx = 0; win = lose = 0; memory contents not cleared. Applies from any state, including mid-playback.
- Reset-state outputs: mode_leds = 001, pattern_out = btn_in (combinational echo), seq_len = 0, win = lose = 0.
- All outputs are registered state decoded combinationally; no extra latency beyond state registers.
- INPUT: pattern_out = btn_in.
  - btn_press with legal btn_in (zero never legal; level=1 requires popcount==1): write mem[count] <= btn_in, count++, play_idx <= 0, next PLAYBACK.
  - Illegal press: ignored, stay in INPUT.
  - level is sampled at the press cycle only.
- PLAYBACK: pattern_out = mem[play_idx]; btn_press ignored.
  - On tick: if play_idx == count-1, play_idx <= 0, rep_idx <= 0, next REPEAT; else play_idx++.
  - Each entry is held one full tick period; the first entry starts immediately on entry.
- REPEAT: pattern_out = btn_in.
  - On btn_press: if btn_in != mem[rep_idx], lose <= 1, next DONE.
  - On match with rep_idx == count-1: if count == DEPTH, win <= 1, next DONE; else next INPUT.
  - On match otherwise: rep_idx++.
  - tick has no effect, except as the timeout source under the optional feature.
- DONE: pattern_out = mem[play_idx].
  - play_idx advances on tick and wraps count-1 -> 0.
  - State held until rst; btn_press ignored; win/lose hold.
- Simultaneous btn_press and tick: press processed; tick applies only to the PLAYBACK/DONE index, and neither state uses press.
- Full memory: count never exceeds DEPTH; INPUT is unreachable once count == DEPTH.
- seq_len = count.
- Memory: DEPTH x W register array, one write port, asynchronous read.

Optional Feature:
SIMON_TIMEOUT_EN:
- Defined:
  - A tick counter clears on REPEAT entry and on every btn_press.
  - It increments on tick in REPEAT.
  - When it reaches TIMEOUT_TICKS with no press that cycle: lose <= 1, next DONE.
  - A press in the same cycle as the expiring tick takes priority.
- Undefined: no counter exists; REPEAT waits indefinitely.

Test Plan:
- W=4, DEPTH=4, level=1: press 0001 -> PLAYBACK shows 0001 for one tick, then REPEAT; press 0001 -> INPUT, seq_len=1.
- level=1, press 0011, then 0000 -> both ignored, stay INPUT, seq_len=0; level=0, press 0011 -> accepted.
- Build 0001, 0010: in REPEAT press 0001 then 0100 -> DONE, lose=1, mode_leds=111, pattern_out cycles 0001, 0010 on ticks.
- Enter and repeat 4 patterns correctly -> after 4th correct press DONE, win=1, seq_len=4, no return to INPUT.
- rst asserted mid-PLAYBACK with count=3 -> next cycle mode_leds=001, seq_len=0, win=lose=0.
- SIMON_TIMEOUT_EN, TIMEOUT_TICKS=8: enter REPEAT, no press for 8 ticks -> DONE, lose=1. Press coinciding with 8th tick -> normal compare, no timeout.
